// File: rtl/jtag_uart_sys_cpu_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtag_uart_sys_cpu_oci_dct_pkg
// Brief   : Shared constants, frame type and slot-insert helper for the
//           OCI debug-trace frame packer.
// Revision: 1.0 - initial release
// ============================================================================
package jtag_uart_sys_cpu_oci_dct_pkg;

  localparam int SYM_W   = 2;
  localparam int SLOTS   = 15;
  localparam int BUF_W   = SYM_W * SLOTS;
  localparam int COUNT_W = 4;

  // One emitted trace frame: packed symbols plus number of valid slots
  typedef struct packed {
    logic [BUF_W-1:0]   buffer;
    logic [COUNT_W-1:0] count;
  } dct_frame_t;

  // Return frame_buf with symbol sym written into slot (LSB-first packing)
  function automatic logic [BUF_W-1:0] put_sym(
    input logic [BUF_W-1:0]   frame_buf,
    input logic [COUNT_W-1:0] slot,
    input logic [SYM_W-1:0]   sym
  );
    logic [BUF_W-1:0] result;
    result = frame_buf;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot == COUNT_W'(k)) begin
        result[k*SYM_W +: SYM_W] = sym;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_uart_sys_cpu_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module  : jtag_uart_sys_cpu_oci_dct_outreg
// Brief   : One-deep valid/ready output register for packed trace frames.
//           The frame holds stable until the consumer takes it.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_uart_sys_cpu_oci_dct_outreg
  import jtag_uart_sys_cpu_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  dct_frame_t load_frame,
  input  logic       dct_ready,
  output logic       dct_valid,
  output dct_frame_t frame
);

  // Load a new frame when told (caller guarantees the slot is free); otherwise
  // drop valid only on a completed handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dct_valid <= 1'b0;
      frame     <= '0;
    end else if (load) begin
      dct_valid <= 1'b1;
      frame     <= load_frame;
    end else if (dct_ready) begin
      dct_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtag_uart_sys_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module  : jtag_uart_sys_cpu_oci_dct_packer
// Brief   : Packs 2-bit trace symbols LSB-first into 30-bit frames and hands
//           them to the trace sink over valid/ready. Supports flush of a
//           partial frame.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_uart_sys_cpu_oci_dct_packer
  import jtag_uart_sys_cpu_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym_data,
  output logic               sym_ready,
  input  logic               flush,
  output logic               dct_valid,
  input  logic               dct_ready,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [COUNT_W-1:0] dct_count,
  output logic               idle
);

  localparam logic [COUNT_W-1:0] C_FULL = COUNT_W'(SLOTS);

  logic [BUF_W-1:0]   r_acc_buf;
  logic [COUNT_W-1:0] r_acc_cnt;
  logic               r_flush_pend;

  logic               w_out_free;
  logic               w_acc_full;
  logic               w_acc_empty;
  logic               w_xfer;
  logic               w_accept;
  logic [COUNT_W-1:0] w_slot;
  logic [BUF_W-1:0]   w_next_buf;
  logic [COUNT_W-1:0] w_next_cnt;
  logic               w_next_pend;
  dct_frame_t         w_load_frame;
  dct_frame_t         w_out_frame;

  // Handshake and transfer decisions depend only on registered state and
  // dct_ready, so sym_ready never depends on sym_valid.
  always_comb begin
    w_acc_full  = (r_acc_cnt == C_FULL);
    w_acc_empty = (r_acc_cnt == '0);
    w_out_free  = !dct_valid || dct_ready;
    w_xfer      = w_out_free && (w_acc_full || (r_flush_pend && !w_acc_empty));
    sym_ready   = !w_acc_full || w_out_free;
    w_accept    = sym_valid && sym_ready;
    idle        = w_acc_empty && !r_flush_pend && !dct_valid;
  end

  // Next accumulator state: a transfer empties it, and an accepted symbol in
  // the same cycle lands in slot 0 of the fresh frame.
  always_comb begin
    w_slot      = w_xfer ? '0 : r_acc_cnt;
    w_next_buf  = w_xfer ? '0 : r_acc_buf;
    w_next_cnt  = w_slot;
    w_next_pend = r_flush_pend;
    if (w_accept) begin
      w_next_buf = put_sym(w_next_buf, w_slot, sym_data);
      w_next_cnt = w_slot + COUNT_W'(1);
    end
    // A new flush request wins so a symbol arriving alongside it is flushed
    if (flush) begin
      w_next_pend = 1'b1;
    end else if (w_xfer) begin
      w_next_pend = 1'b0;
    end else if (r_flush_pend && w_acc_empty && !w_accept) begin
      w_next_pend = 1'b0;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc_buf    <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc_buf    <= w_next_buf;
      r_acc_cnt    <= w_next_cnt;
      r_flush_pend <= w_next_pend;
    end
  end

  // Frame presented to the output register on transfer
  always_comb begin
    w_load_frame.buffer = r_acc_buf;
    w_load_frame.count  = r_acc_cnt;
  end

  jtag_uart_sys_cpu_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_xfer),
    .load_frame (w_load_frame),
    .dct_ready  (dct_ready),
    .dct_valid  (dct_valid),
    .frame      (w_out_frame)
  );

  // Unpack the held frame onto the output ports
  always_comb begin
    dct_buffer = w_out_frame.buffer;
    dct_count  = w_out_frame.count;
  end

endmodule
`default_nettype wire
